alu_issue_ctrl: RTL and testbench

Multi-cycle issue/control stage sitting directly upstream of the execute ALU and downstream of the instruction source and register file. It accepts one MIPS R-type instruction per valid/ready handshake and decodes opcode/funct into the ALU's one-hot operation selects. It presents rs/rt/shamt operands, sequences the ALU's level-sensitive enable, captures the ALU result and issues a single register-file write. Operands and selects are always stable one full cycle before `alu_enable` rises, because the ALU only re-evaluates on enable transitions.

---
 rtl/alu_issue_pkg.sv | 34 +++
 rtl/alu_funct_decode.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 99 +++++++++
 tb/tb_alu_issue_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared FSM state, funct codes and alu_op bit indices for the ALU issue stage.
package alu_issue_pkg;
    typedef enum logic [2:0] {IDLE, DECODE, SETUP, EXEC, WB} state_t;
    localparam int ALU_OP_W = 14;
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SLA  = 6'h01;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_MUL  = 6'h18;
    localparam logic [5:0] F_DIV  = 6'h1A;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_ADDU = 2;
    localparam int OP_SUBU = 3;
    localparam int OP_MUL  = 4;
    localparam int OP_DIV  = 5;
    localparam int OP_AND  = 6;
    localparam int OP_OR   = 7;
    localparam int OP_XOR  = 8;
    localparam int OP_NOR  = 9;
    localparam int OP_SRL  = 10;
    localparam int OP_SLL  = 11;
    localparam int OP_SRA  = 12;
    localparam int OP_SLA  = 13;
endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: R-type opcode/funct to one-hot ALU select; MUL/DIV only with ALU_ISSUE_MULDIV_EN.
module alu_funct_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          funct_i,
    output logic [ALU_OP_W-1:0] op_o,
    output logic                illegal_o
);
    always_comb begin
        op_o = '0;
        case (funct_i)
            F_ADD:  op_o[OP_ADD]  = 1'b1;
            F_SUB:  op_o[OP_SUB]  = 1'b1;
            F_ADDU: op_o[OP_ADDU] = 1'b1;
            F_SUBU: op_o[OP_SUBU] = 1'b1;
            F_AND:  op_o[OP_AND]  = 1'b1;
            F_OR:   op_o[OP_OR]   = 1'b1;
            F_XOR:  op_o[OP_XOR]  = 1'b1;
            F_NOR:  op_o[OP_NOR]  = 1'b1;
            F_SRL:  op_o[OP_SRL]  = 1'b1;
            F_SLL:  op_o[OP_SLL]  = 1'b1;
            F_SRA:  op_o[OP_SRA]  = 1'b1;
            F_SLA:  op_o[OP_SLA]  = 1'b1;
`ifdef ALU_ISSUE_MULDIV_EN
            F_MUL:  op_o[OP_MUL]  = 1'b1;
            F_DIV:  op_o[OP_DIV]  = 1'b1;
`endif
            default: op_o = '0;
        endcase
        if (opcode_i != OPC_RTYPE) op_o = '0;
        illegal_o = (op_o == '0);
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: 5-cycle issue stage sequencing decode, ALU enable and one register write per instruction.
// Define ALU_ISSUE_MULDIV_EN to enable MUL/DIV decode.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    output logic [REG_AW-1:0]   rf_rs_addr,
    output logic [REG_AW-1:0]   rf_rt_addr,
    input  logic [DATA_W-1:0]   rf_rs_data,
    input  logic [DATA_W-1:0]   rf_rt_data,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [DATA_W-1:0]   alu_c,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_enable,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                wb_en,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic                illegal
);
    state_t                state_q, state_d;
    logic [31:0]           instr_q;
    logic [DATA_W-1:0]     alu_a_q, alu_b_q, alu_c_q, wb_data_q;
    logic [ALU_OP_W-1:0]   alu_op_q, dec_op;
    logic [REG_AW-1:0]     wb_addr_q;
    logic                  illegal_q, dec_illegal;

    alu_funct_decode u_dec (
        .opcode_i  (instr_q[31:26]),
        .funct_i   (instr_q[5:0]),
        .op_o      (dec_op),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = instr_valid ? DECODE : IDLE;
            DECODE:  state_d = dec_illegal ? IDLE : SETUP;
            SETUP:   state_d = EXEC;
            EXEC:    state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operands and select are registered on leaving DECODE so they sit stable a full cycle before enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_c_q   <= '0;
            alu_op_q  <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (state_q == DECODE) && dec_illegal;
            if (state_q == IDLE && instr_valid) instr_q <= instr;
            if (state_q == DECODE && !dec_illegal) begin
                alu_a_q   <= rf_rs_data;
                alu_b_q   <= rf_rt_data;
                alu_c_q   <= {{(DATA_W-5){1'b0}}, instr_q[10:6]};
                alu_op_q  <= dec_op;
                wb_addr_q <= REG_AW'(instr_q[15:11]);
            end
            if (state_q == EXEC) begin
                wb_data_q <= alu_result;
                alu_op_q  <= '0;
            end
        end
    end

    assign instr_ready = (state_q == IDLE) && !reset;
    assign rf_rs_addr  = REG_AW'(instr_q[25:21]);
    assign rf_rt_addr  = REG_AW'(instr_q[20:16]);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_c       = alu_c_q;
    assign alu_op      = alu_op_q;
    assign alu_enable  = (state_q == EXEC);
    assign wb_en       = (state_q == WB) && (wb_addr_q != '0);
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign illegal     = illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench with a register-file and ALU model around alu_issue_ctrl.
module tb_alu_issue_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_rs_addr, rf_rt_addr, wb_addr;
    logic [31:0] rf_rs_data, rf_rt_data, alu_a, alu_b, alu_c, alu_result, wb_data;
    logic [13:0] alu_op;
    logic        alu_enable, wb_en, illegal;
    logic [31:0] rf [32];
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [13:0] op;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    alu_issue_ctrl dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_op(alu_op), .alu_enable(alu_enable), .alu_result(alu_result),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal)
    );

    assign rf_rs_data = rf[rf_rs_addr];
    assign rf_rt_data = rf[rf_rt_addr];

    // ALU model: output is only meaningful while enabled, garbage otherwise.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        if (alu_enable)
            case (alu_op)
                14'h0001, 14'h0004: alu_result = alu_a + alu_b;
                14'h0002, 14'h0008: alu_result = alu_a - alu_b;
                14'h0010: alu_result = alu_a * alu_b;
                14'h0020: alu_result = (alu_b != 0) ? alu_a / alu_b : 32'h0;
                14'h0040: alu_result = alu_a & alu_b;
                14'h0080: alu_result = alu_a | alu_b;
                14'h0100: alu_result = alu_a ^ alu_b;
                14'h0200: alu_result = ~(alu_a | alu_b);
                14'h0400: alu_result = alu_b >> alu_c[4:0];
                14'h0800, 14'h2000: alu_result = alu_b << alu_c[4:0];
                14'h1000: alu_result = $unsigned($signed(alu_b) >>> alu_c[4:0]);
                default:  alu_result = 32'hBAD0_BAD0;
            endcase
    end

    function automatic logic [13:0] exp_op(input logic [5:0] fn);
        case (fn)
            6'h20: return 14'h0001;
            6'h22: return 14'h0002;
            6'h21: return 14'h0004;
            6'h23: return 14'h0008;
`ifdef ALU_ISSUE_MULDIV_EN
            6'h18: return 14'h0010;
            6'h1A: return 14'h0020;
`endif
            6'h24: return 14'h0040;
            6'h25: return 14'h0080;
            6'h26: return 14'h0100;
            6'h27: return 14'h0200;
            6'h02: return 14'h0400;
            6'h00: return 14'h0800;
            6'h03: return 14'h1000;
            6'h01: return 14'h2000;
            default: return 14'h0000;
        endcase
    endfunction

    function automatic logic [31:0] exp_res(input logic [5:0] fn, input logic [31:0] a, b, input logic [4:0] sh);
        case (fn)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h18: return a * b;
            6'h1A: return (b != 0) ? a / b : 32'h0;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h02: return b >> sh;
            6'h00, 6'h01: return b << sh;
            6'h03: return $unsigned($signed(b) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] opc, fn, input logic [4:0] rs, rt, rd, sh);
        exp_t e;
        e.op   = (opc == 6'h00) ? exp_op(fn) : 14'h0;
        e.ill  = (e.op == 14'h0);
        e.rd   = rd;
        e.data = exp_res(fn, rf[rs], rf[rt], sh);
        sb.push_back(e);
        @(negedge clock);
        chk("ready_idle", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr = {opc, rs, rt, rd, sh, fn};
        @(negedge clock);
        instr_valid = 1'b0;
        chk("ready_busy", 32'(instr_ready), 32'd0);
        chk("rs_addr", 32'(rf_rs_addr), 32'(rs));
        chk("rt_addr", 32'(rf_rt_addr), 32'(rt));
        @(negedge clock);
        if (sb[0].ill) begin
            e = sb.pop_front();
            chk("illegal_pulse", 32'(illegal), 32'd1);
            chk("illegal_no_en", 32'(alu_enable), 32'd0);
            @(negedge clock);
            chk("illegal_once", 32'(illegal), 32'd0);
            chk("illegal_ready", 32'(instr_ready), 32'd1);
            chk("illegal_no_en2", 32'(alu_enable), 32'd0);
            chk("illegal_no_wb", 32'(wb_en), 32'd0);
        end else begin
            chk("alu_op", 32'(alu_op), 32'(sb[0].op));
            chk("alu_a", alu_a, rf[rs]);
            chk("alu_b", alu_b, rf[rt]);
            chk("alu_c", alu_c, 32'(sh));
            chk("wb_addr", 32'(wb_addr), 32'(rd));
            chk("setup_en_low", 32'(alu_enable), 32'd0);
            chk("no_illegal", 32'(illegal), 32'd0);
            @(negedge clock);
            chk("exec_en", 32'(alu_enable), 32'd1);
            chk("exec_no_wb", 32'(wb_en), 32'd0);
            @(negedge clock);
            e = sb.pop_front();
            chk("wb_en", 32'(wb_en), 32'(e.rd != 5'd0));
            chk("wb_data", wb_data, e.data);
            chk("wb_en_low", 32'(alu_enable), 32'd0);
            chk("wb_op_clr", 32'(alu_op), 32'd0);
            chk("wb_ready", 32'(instr_ready), 32'd0);
            @(negedge clock);
            chk("wb_once", 32'(wb_en), 32'd0);
            chk("back_idle", 32'(instr_ready), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf[6] = 32'h8000_0000;
        rf[8] = 32'hF0F0_1234;
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_en", 32'(alu_enable), 32'd0);
        chk("rst_op", 32'(alu_op), 32'd0);
        chk("rst_wb", 32'(wb_en), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        chk("rst_data", wb_data, 32'd0);
        reset = 1'b0;
        #1 chk("rst_release_ready", 32'(instr_ready), 32'd1);
        issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        issue(6'h00, 6'h00, 5'd0, 5'd2, 5'd4, 5'd4);
        issue(6'h00, 6'h22, 5'd2, 5'd1, 5'd5, 5'd0);
        issue(6'h00, 6'h23, 5'd1, 5'd2, 5'd9, 5'd0);
        issue(6'h00, 6'h21, 5'd8, 5'd6, 5'd10, 5'd0);
        issue(6'h00, 6'h24, 5'd8, 5'd7, 5'd11, 5'd0);
        issue(6'h00, 6'h25, 5'd8, 5'd1, 5'd12, 5'd0);
        issue(6'h00, 6'h26, 5'd8, 5'd2, 5'd13, 5'd0);
        issue(6'h00, 6'h27, 5'd1, 5'd2, 5'd14, 5'd0);
        issue(6'h00, 6'h03, 5'd0, 5'd6, 5'd7, 5'd4);
        issue(6'h00, 6'h02, 5'd0, 5'd6, 5'd7, 5'd4);
        issue(6'h00, 6'h01, 5'd0, 5'd8, 5'd15, 5'd31);
        issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 5'd0);
        issue(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0);
        issue(6'h08, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        rf[1] = 32'd6;
        issue(6'h00, 6'h18, 5'd1, 5'd2, 5'd16, 5'd0);
        issue(6'h00, 6'h1A, 5'd8, 5'd2, 5'd17, 5'd0);
        // Reset mid-EXEC: the in-flight add must vanish without a write.
        @(negedge clock);
        instr_valid = 1'b1;
        instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        @(negedge clock);
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_rst_exec", 32'(alu_enable), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_en", 32'(alu_enable), 32'd0);
        chk("mid_rst_op", 32'(alu_op), 32'd0);
        chk("mid_rst_wb", 32'(wb_en), 32'd0);
        chk("mid_rst_ready", 32'(instr_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("post_rst_ready", 32'(instr_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("post_rst_no_wb", 32'(wb_en), 32'd0);
            chk("post_rst_no_en", 32'(alu_enable), 32'd0);
        end
        issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
